// File: rtl/dm_present_pkg.sv
// dm_present_pkg: PRESENT S-box, bit permutation, key schedules and chain FSM encodings
package dm_present_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC = 2'd1;
  localparam logic [1:0] OUT = 2'd2;
  localparam int RND_W = 6;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [63:0] s_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(s[4*n +: 4]);
    return r;
  endfunction
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[(i % 4) * 16 + i / 4] = s[i];
    return r;
  endfunction
  function automatic logic [79:0] ks80(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction
  function automatic logic [127:0] ks128(input logic [127:0] k, input logic [4:0] rc);
    logic [127:0] r;
    r = {k[66:0], k[127:67]};
    r[127:124] = sbox(r[127:124]);
    r[123:120] = sbox(r[123:120]);
    r[66:62] = r[66:62] ^ rc;
    return r;
  endfunction
endpackage

// File: rtl/dm_present_chain_core.sv
// present_enc_core: iterative PRESENT encryptor, one round per cycle
//   start/pt/key load a new encryption; done pulses once when ct is valid,
//   ct stays stable until the next start.
module present_enc_core
  import dm_present_pkg::*;
#(
  parameter int KEY_W = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      pt,
  input  logic [KEY_W-1:0] key,
  output logic [63:0]      ct,
  output logic             done
);
  logic [63:0] st_q;
  logic [KEY_W-1:0] k_q, k_nxt;
  logic [RND_W-1:0] rnd_q;
  logic run_q, done_q;
  logic [63:0] rk;
  assign rk = k_q[KEY_W-1 -: 64];
  if (KEY_W == 80) begin : g_k80
    assign k_nxt = ks80(k_q, rnd_q[4:0]);
  end else if (KEY_W == 128) begin : g_k128
    assign k_nxt = ks128(k_q, rnd_q[4:0]);
  end else begin : g_bad
    $error("KEY_W must be 80 or 128");
  end
  // After the last round the key register already holds the final round key.
  assign ct = st_q ^ rk;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '0;
      k_q <= '0;
      rnd_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        st_q <= pt;
        k_q <= key;
        rnd_q <= RND_W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (rnd_q == RND_W'(ROUNDS + 1)) begin
          run_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          st_q <= p_layer(s_layer(st_q ^ rk));
          k_q <= k_nxt;
          rnd_q <= rnd_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dm_present_chain.sv
// dm_present_chain: streamed Davies-Meyer hash over PRESENT, H_i = E_Mi(H_i-1) ^ H_i-1
//   msg_valid/msg_ready/msg_block/msg_last: message block input handshake
//   digest_valid/digest_ready/digest: final chaining value output handshake
//   block_cnt: saturating count of blocks absorbed; busy: not IDLE
module dm_present_chain
  import dm_present_pkg::*;
#(
  parameter int          KEY_W  = 80,
  parameter logic [63:0] IV     = 64'h0,
  parameter int          ROUNDS = 31,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [KEY_W-1:0] msg_block,
  input  logic             msg_last,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [63:0]      digest,
  output logic [CNT_W-1:0] block_cnt,
  output logic             busy
);
  logic [1:0] st_q, st_d;
  logic [63:0] chain_q, chain_d, dig_q, dig_d, ct;
  logic last_q, last_d, dvld_q, dvld_d, accept, core_done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign msg_ready = st_q == IDLE;
  assign accept = msg_valid && msg_ready;
  assign busy = st_q != IDLE;
  assign digest_valid = dvld_q;
  assign digest = dig_q;
  assign block_cnt = cnt_q;
  present_enc_core #(.KEY_W(KEY_W), .ROUNDS(ROUNDS)) u_core (
    .clk(clk),
    .rst(rst),
    .start(accept),
    .pt(chain_q),
    .key(msg_block),
    .ct(ct),
    .done(core_done)
  );
  always_comb begin
    st_d = st_q;
    chain_d = chain_q;
    dig_d = dig_q;
    last_d = last_q;
    dvld_d = dvld_q;
    cnt_d = cnt_q;
    if (accept) begin
      st_d = ENC;
      last_d = msg_last;
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
    if (st_q == ENC && core_done) begin
      chain_d = ct ^ chain_q;
      st_d = last_q ? OUT : IDLE;
      dig_d = last_q ? ct ^ chain_q : dig_q;
      dvld_d = last_q;
    end
    if (st_q == OUT && digest_ready) begin
      st_d = IDLE;
      dvld_d = 1'b0;
      chain_d = IV;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      chain_q <= IV;
      dig_q <= '0;
      last_q <= 1'b0;
      dvld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      chain_q <= chain_d;
      dig_q <= dig_d;
      last_q <= last_d;
      dvld_q <= dvld_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dm_present_chain.sv
// tb_dm_present_chain: directed vector bench for dm_present_chain
module tb_dm_present_chain;
  logic clk = 1'b0;
  logic rst, mv, ml, dr;
  logic [79:0] mb80;
  logic [127:0] mb128;
  logic rdy_a, dv_a, busy_a, rdy_b, dv_b, busy_b, rdy_c, dv_c, busy_c;
  logic [63:0] dg_a, dg_b, dg_c;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dm_present_chain #(.KEY_W(80)) u_a (
    .clk(clk), .rst(rst), .msg_valid(mv), .msg_ready(rdy_a), .msg_block(mb80), .msg_last(ml),
    .digest_valid(dv_a), .digest_ready(dr), .digest(dg_a), .block_cnt(cnt_a), .busy(busy_a)
  );
  dm_present_chain #(.KEY_W(128), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .msg_valid(mv), .msg_ready(rdy_b), .msg_block(mb128), .msg_last(ml),
    .digest_valid(dv_b), .digest_ready(dr), .digest(dg_b), .block_cnt(cnt_b), .busy(busy_b)
  );
  dm_present_chain #(.KEY_W(80), .IV(64'hFFFF_FFFF_FFFF_FFFF)) u_c (
    .clk(clk), .rst(rst), .msg_valid(mv), .msg_ready(rdy_c), .msg_block(mb80), .msg_last(ml),
    .digest_valid(dv_c), .digest_ready(dr), .digest(dg_c), .block_cnt(cnt_c), .busy(busy_c)
  );
  function automatic logic [63:0] penc(input logic [63:0] pt, input logic [127:0] key, input bit k128);
    logic [63:0] s, t;
    logic [127:0] k;
    logic [63:0] sb;
    sb = 64'h21748FE3DA09B65C;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ (k128 ? k[127:64] : k[79:16]);
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sb[4*s[4*n +: 4] +: 4];
      for (int i = 0; i < 64; i++) s[i == 63 ? 63 : (i * 16) % 63] = t[i];
      if (k128) begin
        k = {k[66:0], k[127:67]};
        k[127:124] = sb[4*k[127:124] +: 4];
        k[123:120] = sb[4*k[123:120] +: 4];
        k[66:62] = k[66:62] ^ 5'(r);
      end else begin
        k[79:0] = {k[18:0], k[79:19]};
        k[79:76] = sb[4*k[79:76] +: 4];
        k[19:15] = k[19:15] ^ 5'(r);
      end
    end
    return s ^ (k128 ? k[127:64] : k[79:16]);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic offer(input logic [79:0] k80, input logic [127:0] k128, input logic last);
    int n = 0;
    while (!rdy_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_to_accept", rdy_a, 1);
    mv = 1'b1;
    mb80 = k80;
    mb128 = k128;
    ml = last;
    @(posedge clk); #1;
    mv = 1'b0;
  endtask
  task automatic wait_digest(output int lat);
    lat = 0;
    while (!dv_a && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic take();
    dr = 1'b1;
    @(posedge clk); #1;
    dr = 1'b0;
    chk("dv_after_take", dv_a, 0);
    chk("cnt_after_take", cnt_a, 0);
    chk("ready_after_take", rdy_a, 1);
  endtask
  typedef struct {
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [63:0]  e80;
    logic [63:0]  e128;
    logic [63:0]  eff;
  } vec_t;
  vec_t tbl[3];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int lat, bad;
    logic [63:0] h1, h128, d0, ea, eb;
    tbl[0] = '{80'h0, 128'h0, 64'h5579C1387B228445, 64'h96DB702A2E6900AF, 64'h5EED0038D097BE84};
    tbl[1] = '{{80{1'b1}}, {128{1'b1}}, 64'hE72C46C0F5945049, penc(64'h0, {128{1'b1}}, 1'b1),
               64'hCCCC232CDECDEF2D};
    tbl[2] = '{80'h0123456789ABCDEF0123, 128'hFEDCBA98765432100123456789ABCDEF,
               penc(64'h0, {48'h0, 80'h0123456789ABCDEF0123}, 1'b0),
               penc(64'h0, 128'hFEDCBA98765432100123456789ABCDEF, 1'b1),
               penc({64{1'b1}}, {48'h0, 80'h0123456789ABCDEF0123}, 1'b0) ^ {64{1'b1}}};
    rst = 1'b1;
    mv = 1'b0;
    ml = 1'b0;
    dr = 1'b0;
    mb80 = '0;
    mb128 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_dv", dv_a, 0);
    chk("rst_digest", dg_a, 0);
    chk("rst_cnt", cnt_a, 0);
    foreach (tbl[v]) begin
      offer(tbl[v].k80, tbl[v].k128, 1'b1);
      wait_digest(lat);
      chk("latency", lat, 33);
      chk("digest80", dg_a, tbl[v].e80);
      chk("digest128", dg_b, tbl[v].e128);
      chk("digest80_iv1", dg_c, tbl[v].eff);
      chk("cnt_single", cnt_a, 1);
      chk("busy_out", busy_a, 1);
      chk("ready_out", rdy_a, 0);
      take();
    end
    mv = 1'b1;
    mb80 = '0;
    mb128 = '0;
    ml = 1'b0;
    @(posedge clk); #1;
    ml = 1'b1;
    bad = 0;
    lat = 0;
    while (!rdy_a && lat < 100) begin
      if (cnt_a != 16'd1 || dv_a) bad++;
      @(posedge clk); #1;
      lat++;
    end
    chk("held_valid_no_extra", bad, 0);
    chk("mid_ready", rdy_a, 1);
    chk("mid_no_digest", dv_a, 0);
    chk("mid_cnt", cnt_a, 1);
    @(posedge clk); #1;
    mv = 1'b0;
    chk("second_cnt", cnt_a, 2);
    wait_digest(lat);
    chk("two_block_latency", lat, 33);
    h1 = 64'h5579C1387B228445;
    h128 = 64'h96DB702A2E6900AF;
    chk("two_block80", dg_a, penc(h1, 128'h0, 1'b0) ^ h1);
    chk("two_block128", dg_b, penc(h128, 128'h0, 1'b1) ^ h128);
    chk("two_block_cnt", cnt_a, 2);
    d0 = dg_a;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!dv_a || dg_a !== d0 || rdy_a) bad++;
    end
    chk("backpressure_hold", bad, 0);
    take();
    dr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready_ignored_dv", dv_a, 0);
    chk("idle_ready_ignored_busy", busy_a, 0);
    dr = 1'b0;
    offer(80'h0, 128'h0, 1'b1);
    wait_digest(lat);
    chk("rehash_from_iv", dg_a, 64'h5579C1387B228445);
    take();
    offer(80'h0, 128'h0, 1'b1);
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_ready", rdy_a, 1);
    chk("abort_cnt", cnt_a, 0);
    bad = 0;
    repeat (40) begin
      if (dv_a || busy_a) bad++;
      @(posedge clk); #1;
    end
    chk("abort_no_digest", bad, 0);
    offer(80'h0, 128'h0, 1'b1);
    wait_digest(lat);
    chk("after_abort_digest", dg_a, 64'h5579C1387B228445);
    chk("after_abort_cnt", cnt_a, 1);
    take();
    ea = 64'h0;
    eb = 64'h0;
    for (int i = 0; i < 4; i++) begin
      offer(80'h0, 128'h0, i == 3);
      ea = penc(ea, 128'h0, 1'b0) ^ ea;
      eb = penc(eb, 128'h0, 1'b1) ^ eb;
    end
    wait_digest(lat);
    chk("four_cnt80", cnt_a, 4);
    chk("sat_cnt128", cnt_b, 3);
    chk("four_digest80", dg_a, ea);
    chk("sat_digest128", dg_b, eb);
    take();
    chk("sat_cnt_cleared", cnt_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_present_chain.md
Name: dm_present_chain

Overview:
- Parametrised Davies-Meyer compression engine over the PRESENT block cipher, chaining an arbitrary number of message blocks: H_i = E_{M_i}(H_{i-1}) XOR H_{i-1}, with H_0 = IV.
- Each message block is the cipher key (80 or 128 bits). The chaining value is the 64-bit plaintext.
- Sits between the message-block feeder and the digest consumer in the IoT hashing path.
- Replaces the single-shot DM hash with streamed multi-block hashing, valid/ready handshakes and a block counter.

Parameters:
KEY_W, 80, message block / cipher key width; legal values 80 or 128, anything else is an elaboration error
IV, 64'h0, initial chaining value H_0
ROUNDS, 31, PRESENT round count; the last round is followed by the final key XOR
CNT_W, 16, width of the block counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
msg_valid  in  1  message block offered
msg_ready  out  1  engine accepts a block this cycle
msg_block  in  KEY_W  message block, used as the cipher key
msg_last  in  1  offered block is the final block of the message
digest_valid  out  1  digest available
digest_ready  in  1  consumer takes the digest
digest  out  64  final chaining value
block_cnt  out  CNT_W  blocks absorbed in the current message
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst high at a clk edge), from any state including mid-encryption:
  - state goes to IDLE; chaining register = IV; block_cnt = 0.
  - digest_valid = 0; digest = 0; msg_ready = 1 from the next cycle; busy = 0.
  - the core is aborted, and any in-flight result is discarded.
- State IDLE:
  - msg_ready = 1.
  - On msg_valid && msg_ready: latch msg_block and msg_last, start the core with pt = chaining register, block_cnt += 1, go to ENC.
- State ENC:
  - msg_ready = 0.
  - The core runs one round per cycle. core_done asserts exactly ROUNDS+1 cycles after the acceptance edge (32 by default).
  - On core_done: chaining register <= ct XOR chaining register.
    - If the latched last flag is 0, go to IDLE.
    - If it is 1, digest <= the new value, digest_valid <= 1, go to OUT.
  - Block-to-block throughput is ROUNDS+2 cycles per block (33 by default), including the IDLE acceptance cycle.
- State OUT:
  - digest_valid = 1; digest is held stable; msg_ready = 0.
  - On digest_ready: digest_valid <= 0, chaining register <= IV, block_cnt <= 0, go to IDLE.
  - digest_ready while digest_valid = 0 is ignored.
- msg_valid during ENC or OUT is not accepted. The producer must hold msg_block stable until the handshake completes.
- block_cnt saturates at all-ones and does not wrap. Hashing continues normally past saturation.
- Latency from acceptance of the last block to digest_valid = 1 is ROUNDS+2 cycles.

Decomposition:
- Package dm_present_pkg holds:
  - the S-box table and pLayer bit-mapping function.
  - the key-schedule update functions for 80- and 128-bit keys, selected by KEY_W.
  - the state enum {IDLE, ENC, OUT} and the round-counter width constant.
- Sub-module present_enc_core, iterative, parametrised by KEY_W and ROUNDS:
  - ports: clk, rst, start, pt[63:0], key[KEY_W-1:0], ct[63:0], done.
  - done is a 1-cycle pulse; ct is held stable until the next start.
  - the core holds its own round-key register and round counter.

Test Plan:
- Single-block, KEY_W=80, IV=0, msg_block=0, msg_last=1 -> digest_valid 33 cycles after acceptance, digest=64'h5579C1387B228445, block_cnt=1.
- Single-block, KEY_W=128, IV=0, msg_block=0, msg_last=1 -> digest=64'h96DB702A2E6900AF.
- KEY_W=80, IV=64'hFFFFFFFFFFFFFFFF, msg_block=0, msg_last=1 -> digest = 64'hA112FFC72F68417B XOR 64'hFFFFFFFFFFFFFFFF = 64'h5EED0038D097BE84.
- Two-block message, KEY_W=80, IV=0, blocks 0 then 0:
  - after the first block, msg_ready is back to 1 and there is no digest_valid.
  - the final digest equals the software model E_0(5579C1387B228445) XOR 5579C1387B228445.
  - block_cnt=2.
  - msg_valid held high through ENC yields no extra acceptance.
- Backpressure: hold digest_ready=0 for 10 cycles -> digest and digest_valid stay stable and msg_ready stays 0. Then assert digest_ready for one cycle -> IDLE with block_cnt=0, and the next message hashed from IV gives the same result as the first.
- Reset mid-ENC at cycle 15 -> busy=0 next cycle and digest_valid never asserts. A fresh single block 0 then yields 64'h5579C1387B228445, proving the chaining register was restored to IV.
